// File: rtl/mam_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single MAM-style memory port.
// A grant covers the whole transaction: the request handshake and every data
// beat that follows it. Re-arbitration happens only after returning to IDLE.
module mam_mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [1:0]                s_req_valid,
  output logic [1:0]                s_req_ready,
  input  logic [1:0]                s_req_rw,
  input  logic [2*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [1:0]                s_req_burst,
  input  logic [2*14-1:0]           s_req_beats,
  input  logic [1:0]                s_write_valid,
  input  logic [2*DATA_WIDTH-1:0]   s_write_data,
  input  logic [2*DATA_WIDTH/8-1:0] s_write_strb,
  output logic [1:0]                s_write_ready,
  output logic [1:0]                s_read_valid,
  output logic [DATA_WIDTH-1:0]     s_read_data,
  input  logic [1:0]                s_read_ready,

  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic                      mem_req_burst,
  output logic [13:0]               mem_req_beats,
  output logic                      mem_write_valid,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  output logic [DATA_WIDTH/8-1:0]   mem_write_strb,
  input  logic                      mem_write_ready,
  input  logic                      mem_read_valid,
  input  logic [DATA_WIDTH-1:0]     mem_read_data,
  output logic                      mem_read_ready,

  output logic                      grant,
  output logic                      busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} state_t;

  state_t      state, state_nxt;
  logic        grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic [13:0] count, count_nxt;

  // Fields of the currently granted requester.
  logic        sel_req_valid;
  logic        sel_rw;
  logic        sel_burst;
  logic [13:0] sel_beats;
  logic        sel_write_valid;
  logic        sel_read_ready;
  logic [1:0]  grant_oh;
  logic        pick;
  logic        wr_hs;
  logic        rd_hs;
  logic [13:0] load_count;

  assign sel_req_valid   = s_req_valid[grant];
  assign sel_rw          = s_req_rw[grant];
  assign sel_burst       = s_req_burst[grant];
  assign sel_beats       = grant ? s_req_beats[27:14] : s_req_beats[13:0];
  assign sel_write_valid = s_write_valid[grant];
  assign sel_read_ready  = s_read_ready[grant];
  assign grant_oh        = grant ? 2'b10 : 2'b01;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  assign pick       = (s_req_valid == 2'b11) ? ~last_grant : s_req_valid[1];
  assign wr_hs      = sel_write_valid & mem_write_ready;
  assign rd_hs      = mem_read_valid & sel_read_ready;
  // A burst with zero beats still moves one beat.
  assign load_count = (sel_burst && sel_beats != 14'd0) ? sel_beats : 14'd1;

  // Payload fields are steered by grant at all times; only valids/readies are gated by state.
  assign mem_req_rw     = sel_rw;
  assign mem_req_addr   = grant ? s_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_req_addr[ADDR_WIDTH-1:0];
  assign mem_req_burst  = sel_burst;
  assign mem_req_beats  = sel_beats;
  assign mem_write_data = grant ? s_write_data[2*DATA_WIDTH-1:DATA_WIDTH] : s_write_data[DATA_WIDTH-1:0];
  assign mem_write_strb = grant ? s_write_strb[2*STRB_WIDTH-1:STRB_WIDTH] : s_write_strb[STRB_WIDTH-1:0];
  assign s_read_data    = mem_read_data;
  assign busy           = (state != IDLE);

  // State register: FSM state, grant bookkeeping and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      count      <= 14'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      count      <= count_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, request handshake, beat counting.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    count_nxt      = count;
    unique case (state)
      IDLE: begin
        if (|s_req_valid) begin
          state_nxt = REQ;
          grant_nxt = pick;
        end
      end
      REQ: begin
        if (!sel_req_valid) begin
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          count_nxt = load_count;
          state_nxt = sel_rw ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_hs) begin
          count_nxt = count - 14'd1;
          if (count == 14'd1) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end
      READ: begin
        if (rd_hs) begin
          count_nxt = count - 14'd1;
          if (count == 14'd1) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: open exactly one handshake path toward the granted requester.
  always_comb begin
    s_req_ready     = 2'b00;
    s_write_ready   = 2'b00;
    s_read_valid    = 2'b00;
    mem_req_valid   = 1'b0;
    mem_write_valid = 1'b0;
    mem_read_ready  = 1'b0;
    unique case (state)
      REQ: begin
        mem_req_valid = sel_req_valid;
        s_req_ready   = mem_req_ready ? grant_oh : 2'b00;
      end
      WRITE: begin
        mem_write_valid = sel_write_valid;
        s_write_ready   = mem_write_ready ? grant_oh : 2'b00;
      end
      READ: begin
        s_read_valid   = mem_read_valid ? grant_oh : 2'b00;
        mem_read_ready = sel_read_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Self-checking bench for mam_mem_arbiter: a transaction-level model predicts
// every output each cycle; directed scenarios pin the model with literal values.
module tb_mam_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      s_req_valid   = '0;
  logic [1:0]      s_req_rw      = '0;
  logic [1:0]      s_req_burst   = '0;
  logic [1:0]      s_write_valid = '0;
  logic [1:0]      s_read_ready  = '0;
  logic [AW-1:0]   addr_a  [2]   = '{default: '0};
  logic [13:0]     beats_a [2]   = '{default: '0};
  logic [DW-1:0]   wdata_a [2]   = '{default: '0};
  logic [SW-1:0]   strb_a  [2]   = '{default: '0};
  logic            mem_req_ready   = 1'b0;
  logic            mem_write_ready = 1'b0;
  logic            mem_read_valid  = 1'b0;
  logic [DW-1:0]   mem_read_data   = '0;

  logic [1:0]      s_req_ready, s_write_ready, s_read_valid;
  logic [DW-1:0]   s_read_data;
  logic            mem_req_valid, mem_req_rw, mem_req_burst;
  logic [AW-1:0]   mem_req_addr;
  logic [13:0]     mem_req_beats;
  logic            mem_write_valid, mem_read_ready;
  logic [DW-1:0]   mem_write_data;
  logic [SW-1:0]   mem_write_strb;
  logic            grant, busy;

  logic [2*AW-1:0] s_req_addr;
  logic [27:0]     s_req_beats;
  logic [2*DW-1:0] s_write_data;
  logic [2*SW-1:0] s_write_strb;
  assign s_req_addr   = {addr_a[1], addr_a[0]};
  assign s_req_beats  = {beats_a[1], beats_a[0]};
  assign s_write_data = {wdata_a[1], wdata_a[0]};
  assign s_write_strb = {strb_a[1], strb_a[0]};

  mam_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
    .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_write_ready(s_write_ready), .s_read_valid(s_read_valid), .s_read_data(s_read_data),
    .s_read_ready(s_read_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_burst(mem_req_burst), .mem_req_beats(mem_req_beats),
    .mem_write_valid(mem_write_valid), .mem_write_data(mem_write_data),
    .mem_write_strb(mem_write_strb), .mem_write_ready(mem_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
    .mem_read_ready(mem_read_ready), .grant(grant), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner (-1 = nobody), beats left (0 = request
  // not yet accepted), direction, who was served last, current grant index.
  typedef struct packed {
    int   owner;
    int   left;
    logic wr;
    int   last;
    int   grant;
  } model_t;

  localparam model_t MODEL_RESET = '{owner: -1, left: 0, wr: 1'b0, last: 1, grant: 0};
  model_t m = MODEL_RESET;

  function automatic model_t model_step(input model_t cur);
    model_t n;
    int     g;
    logic   hs;
    n = cur;
    g = cur.grant;
    if (cur.owner < 0) begin
      if (s_req_valid != 2'b00) begin
        n.owner = (s_req_valid == 2'b11) ? 1 - cur.last : (s_req_valid[1] ? 1 : 0);
        n.grant = n.owner;
        n.left  = 0;
      end
    end else if (cur.left == 0) begin
      if (!s_req_valid[g]) begin
        n.owner = -1;
      end else if (mem_req_ready) begin
        n.left = (s_req_burst[g] && beats_a[g] != 14'd0) ? int'(beats_a[g]) : 1;
        n.wr   = s_req_rw[g];
      end
    end else begin
      hs = cur.wr ? (s_write_valid[g] && mem_write_ready) : (mem_read_valid && s_read_ready[g]);
      if (hs) begin
        n.left = cur.left - 1;
        if (n.left == 0) begin
          n.owner = -1;
          n.last  = g;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= MODEL_RESET;
    else      m <= model_step(m);
  end

  // Observed memory-side transfers, for the directed scenarios.
  int          q_req_grant [$];
  logic [AW-1:0] q_req_addr [$];
  logic        q_req_rw    [$];
  logic        q_req_burst [$];
  logic [13:0] q_req_beats [$];
  int          q_wr_grant  [$];
  logic [DW-1:0] q_wr_data [$];
  int          q_rd_grant  [$];

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [1:0] e_req_ready, e_write_ready, e_read_valid;
    logic       e_mem_req_valid, e_mem_write_valid, e_mem_read_ready;
    int         g;
    g = m.grant;
    e_req_ready = '0; e_write_ready = '0; e_read_valid = '0;
    e_mem_req_valid = 1'b0; e_mem_write_valid = 1'b0; e_mem_read_ready = 1'b0;
    if (m.owner >= 0 && m.left == 0) begin
      e_mem_req_valid = s_req_valid[g];
      e_req_ready[g]  = mem_req_ready;
      check("mem_req_rw", 64'(mem_req_rw), 64'(s_req_rw[g]));
      check("mem_req_addr", 64'(mem_req_addr), 64'(addr_a[g]));
      check("mem_req_burst", 64'(mem_req_burst), 64'(s_req_burst[g]));
      check("mem_req_beats", 64'(mem_req_beats), 64'(beats_a[g]));
    end else if (m.owner >= 0 && m.wr) begin
      e_mem_write_valid = s_write_valid[g];
      e_write_ready[g]  = mem_write_ready;
      check("mem_write_data", 64'(mem_write_data), 64'(wdata_a[g]));
      check("mem_write_strb", 64'(mem_write_strb), 64'(strb_a[g]));
    end else if (m.owner >= 0) begin
      e_read_valid[g]  = mem_read_valid;
      e_mem_read_ready = s_read_ready[g];
    end
    check("ctrl",
          64'({s_req_ready, s_write_ready, s_read_valid, mem_req_valid, mem_write_valid,
               mem_read_ready, busy, grant}),
          64'({e_req_ready, e_write_ready, e_read_valid, e_mem_req_valid, e_mem_write_valid,
               e_mem_read_ready, (m.owner >= 0), m.grant[0]}));
    check("s_read_data", 64'(s_read_data), 64'(mem_read_data));
    if (rst) begin
      if (mem_req_valid && mem_req_ready) begin
        q_req_grant.push_back(int'(grant));
        q_req_addr.push_back(mem_req_addr);
        q_req_rw.push_back(mem_req_rw);
        q_req_burst.push_back(mem_req_burst);
        q_req_beats.push_back(mem_req_beats);
      end
      if (mem_write_valid && mem_write_ready) begin
        q_wr_grant.push_back(int'(grant));
        q_wr_data.push_back(mem_write_data);
      end
      if (mem_read_valid && mem_read_ready) q_rd_grant.push_back(int'(grant));
    end
  end

  logic auto_drop  = 1'b0;  // requester withdraws its request once accepted
  logic auto_wdata = 1'b0;  // requester advances write data after each accepted beat
  logic toggle_wr  = 1'b0;  // memory alternates write backpressure every cycle

  task automatic step();
    logic [1:0] hs_r, hs_w;
    @(negedge clk);
    hs_r = s_req_valid & s_req_ready;
    hs_w = s_write_valid & s_write_ready;
    @(posedge clk);
    #1;
    if (auto_drop) s_req_valid = s_req_valid & ~hs_r;
    if (auto_wdata) for (int i = 0; i < 2; i++) if (hs_w[i]) wdata_a[i] = wdata_a[i] + 1'b1;
    if (toggle_wr) mem_write_ready = ~mem_write_ready;
  endtask

  function automatic int log_size(input int which);
    case (which)
      0:       return q_req_grant.size();
      1:       return q_wr_grant.size();
      default: return q_rd_grant.size();
    endcase
  endfunction

  // Bounded wait for a number of observed transfers (0 req, 1 write, 2 read).
  task automatic wait_count(input string name, input int which, input int n, input int budget);
    int c;
    c = 0;
    while (log_size(which) < n && c < budget) begin
      step();
      c++;
    end
    check(name, 64'(log_size(which)), 64'(n));
  endtask

  task automatic clear_logs();
    q_req_grant.delete(); q_req_addr.delete(); q_req_rw.delete();
    q_req_burst.delete(); q_req_beats.delete();
    q_wr_grant.delete(); q_wr_data.delete(); q_rd_grant.delete();
  endtask

  task automatic idle_inputs();
    s_req_valid = '0; s_req_rw = '0; s_req_burst = '0; s_write_valid = '0; s_read_ready = '0;
    for (int i = 0; i < 2; i++) begin
      addr_a[i] = '0; beats_a[i] = '0; wdata_a[i] = '0; strb_a[i] = '0;
    end
    mem_req_ready = 1'b0; mem_write_ready = 1'b0; mem_read_valid = 1'b0; mem_read_data = '0;
    auto_drop = 1'b0; auto_wdata = 1'b0; toggle_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_grant", 64'(grant), 64'd0);
    clear_logs();
    rst = 1'b1;
  endtask

  task automatic randomize_inputs();
    s_req_valid   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    s_req_rw      = 2'($urandom);
    s_req_burst   = 2'($urandom);
    s_write_valid = 2'($urandom);
    s_read_ready  = 2'($urandom);
    for (int i = 0; i < 2; i++) begin
      addr_a[i]  = $urandom;
      beats_a[i] = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(0, 40)) : 14'($urandom_range(0, 4));
      wdata_a[i] = DW'($urandom);
      strb_a[i]  = SW'($urandom);
    end
    mem_req_ready   = ($urandom_range(0, 2) != 0);
    mem_write_ready = ($urandom_range(0, 2) != 0);
    mem_read_valid  = ($urandom_range(0, 2) != 0);
    mem_read_data   = DW'($urandom);
  endtask

  initial begin
    // Single write from requester 0.
    do_reset();
    s_req_valid = 2'b01; s_req_rw = 2'b01; addr_a[0] = 32'h0; s_req_burst = 2'b00;
    s_write_valid = 2'b01; wdata_a[0] = 16'h000F; strb_a[0] = 2'b11;
    mem_req_ready = 1'b1; mem_write_ready = 1'b1; auto_drop = 1'b1;
    wait_count("single_beats", 1, 1, 20);
    check("single_busy_after_beat", 64'(busy), 64'd0);
    check("single_req_count", 64'(q_req_grant.size()), 64'd1);
    if (q_req_grant.size() >= 1) begin
      check("single_req_addr", 64'(q_req_addr[0]), 64'h0);
      check("single_req_rw", 64'(q_req_rw[0]), 64'd1);
      check("single_req_burst", 64'(q_req_burst[0]), 64'd0);
      check("single_req_grant", 64'(q_req_grant[0]), 64'd0);
    end
    if (q_wr_grant.size() >= 1) check("single_wr_data", 64'(q_wr_data[0]), 64'h000F);

    // Simultaneous single writes: strict alternation starting with requester 0.
    do_reset();
    s_req_valid = 2'b11; s_req_rw = 2'b11; s_write_valid = 2'b11;
    wdata_a[0] = 16'h1111; wdata_a[1] = 16'h2222; strb_a[0] = 2'b11; strb_a[1] = 2'b01;
    mem_req_ready = 1'b1; mem_write_ready = 1'b1;
    wait_count("rr_beats", 1, 4, 40);
    s_req_valid = 2'b00;
    for (int i = 0; i < 4 && i < q_wr_grant.size(); i++)
      check($sformatf("rr_order_%0d", i), 64'(q_wr_grant[i]), 64'(i % 2));

    // Burst of 7 writes from requester 1 with toggling backpressure.
    do_reset();
    s_req_valid = 2'b10; s_req_rw = 2'b10; s_req_burst = 2'b10; beats_a[1] = 14'd7;
    s_write_valid = 2'b10; wdata_a[1] = 16'h0000; strb_a[1] = 2'b11;
    mem_req_ready = 1'b1; mem_write_ready = 1'b1;
    auto_drop = 1'b1; auto_wdata = 1'b1; toggle_wr = 1'b1;
    wait_count("burst_wr_beats", 1, 7, 60);
    check("burst_wr_idle", 64'(busy), 64'd0);
    for (int i = 0; i < q_wr_grant.size(); i++) begin
      check($sformatf("burst_wr_data_%0d", i), 64'(q_wr_data[i]), 64'(i));
      check($sformatf("burst_wr_grant_%0d", i), 64'(q_wr_grant[i]), 64'd1);
    end

    // Read burst of 16 from requester 0 while requester 1 waits.
    do_reset();
    s_req_valid = 2'b11; s_req_rw = 2'b00; s_req_burst = 2'b01; beats_a[0] = 14'd16;
    s_read_ready = 2'b11; mem_req_ready = 1'b1; mem_read_valid = 1'b1; mem_read_data = 16'hBEEF;
    auto_drop = 1'b1;
    wait_count("burst_rd_beats", 2, 16, 60);
    check("burst_rd_reqs_during", 64'(q_req_grant.size()), 64'd1);
    wait_count("burst_rd_next_req", 0, 2, 10);
    if (q_req_grant.size() >= 2) begin
      check("burst_rd_first", 64'(q_req_grant[0]), 64'd0);
      check("burst_rd_first_beats", 64'(q_req_beats[0]), 64'd16);
      check("burst_rd_second", 64'(q_req_grant[1]), 64'd1);
    end

    // Asynchronous reset in the middle of an 8-beat write burst.
    do_reset();
    s_req_valid = 2'b01; s_req_rw = 2'b01; s_req_burst = 2'b01; beats_a[0] = 14'd8;
    s_write_valid = 2'b01; strb_a[0] = 2'b11; mem_req_ready = 1'b1; mem_write_ready = 1'b1;
    auto_drop = 1'b1;
    wait_count("midrst_beats", 1, 3, 20);
    check("midrst_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1 check("midrst_outputs_zero",
             64'({s_req_ready, s_write_ready, s_read_valid, mem_req_valid, mem_write_valid,
                  mem_read_ready, busy}), 64'd0);
    clear_logs();
    s_req_valid = 2'b11; s_req_rw = 2'b11; s_req_burst = 2'b00; s_write_valid = 2'b11;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_count("midrst_after_req", 0, 1, 10);
    if (q_req_grant.size() >= 1) check("midrst_winner", 64'(q_req_grant[0]), 64'd0);

    // Withdrawal before the handshake, then a zero-beat burst.
    do_reset();
    s_req_valid = 2'b01; s_req_rw = 2'b00; mem_req_ready = 1'b0;
    repeat (3) step();
    check("withdraw_busy_in_req", 64'(busy), 64'd1);
    s_req_valid = 2'b00;
    repeat (2) step();
    check("withdraw_idle", 64'(busy), 64'd0);
    check("withdraw_no_req", 64'(q_req_grant.size() + q_rd_grant.size()), 64'd0);
    s_req_valid = 2'b01; s_req_rw = 2'b01; s_req_burst = 2'b01; beats_a[0] = 14'd0;
    s_write_valid = 2'b01; wdata_a[0] = 16'hA5A5; strb_a[0] = 2'b10;
    mem_req_ready = 1'b1; mem_write_ready = 1'b1; auto_drop = 1'b1;
    wait_count("zero_burst_first", 1, 1, 20);
    repeat (6) step();
    check("zero_burst_one_beat", 64'(q_wr_grant.size()), 64'd1);
    if (q_wr_grant.size() >= 1) check("zero_burst_data", 64'(q_wr_data[0]), 64'hA5A5);

    // Randomized traffic against the model, with one asynchronous reset pulse.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if (i == 1500) rst = 1'b0;
      if (i == 1501) rst = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
